mem_stage_controller: RTL

MEM_STAGE_CONTROLLER -- requirements
Module: mem_stage_controller

---
 rtl/mem_stage_controller_pkg.sv | 17 +
 rtl/load_extender.sv | 17 +
 rtl/mem_stage_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_controller_pkg.sv
// Shared widths, decode constants and FSM encoding for the memory pipeline stage.
package mem_stage_controller_pkg;

    localparam int WORD_WIDTH           = 32;
    localparam int REGISTER_INDEX_WIDTH = 5;

    localparam logic [6:0] STORE_OPCODE = 7'b0100011;
    localparam logic [2:0] FUNCT3_BYTE  = 3'b000;
    localparam logic [2:0] FUNCT3_WORD  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/load_extender.sv
// Combinational load formatting: byte loads are sign-extended from bit 7, word loads pass through.
module load_extender #(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] read_data,
    input  logic                  byte_access,
    output logic [WORD_WIDTH-1:0] load_value
);

    always_comb begin
        load_value = read_data;
        if (byte_access) begin
            load_value = {{(WORD_WIDTH-8){read_data[7]}}, read_data[7:0]};
        end
    end

endmodule

// File: rtl/mem_stage_controller.sv
// Memory stage: ALU results pass through in one cycle; loads/stores run a single
// request/done-pulse transaction against the data cache while stalling upstream.
module mem_stage_controller
    import mem_stage_controller_pkg::*;
#(
    parameter int WORD_WIDTH           = mem_stage_controller_pkg::WORD_WIDTH,
    parameter int REGISTER_INDEX_WIDTH = mem_stage_controller_pkg::REGISTER_INDEX_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic [WORD_WIDTH-1:0]           instruction_in,
    input  logic [WORD_WIDTH-1:0]           extended_inmediate_in,
    input  logic                            cu_mem_to_reg_in,
    input  logic                            cu_reg_write_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
    input  logic [WORD_WIDTH-1:0]           alu_result_in,
    input  logic                            alu_zero_in,
    input  logic                            active_in,
    input  logic [WORD_WIDTH-1:0]           store_data_in,

    output logic                            mem_req_out,
    output logic                            mem_write_out,
    output logic                            mem_byte_out,
    output logic [WORD_WIDTH-1:0]           mem_address_out,
    output logic [WORD_WIDTH-1:0]           mem_write_data_out,
    input  logic                            mem_ready_in,
    input  logic [WORD_WIDTH-1:0]           mem_read_data_in,

    output logic [WORD_WIDTH-1:0]           wb_value_out,
    output logic [REGISTER_INDEX_WIDTH-1:0] wb_destination_out,
    output logic                            wb_reg_write_out,
    output logic                            wb_active_out,

    output logic                            stall_out,
    output logic                            misaligned_out,
    output logic [1:0]                      debug_state
);

    // Handshake: upstream presents an op with active_in=1 and must hold it while
    // stall_out=1. The cache sees mem_req_out for one cycle and answers with a
    // single mem_ready_in pulse; a pulse coinciding with the request is ignored.

    state_t                          state;
    logic                            pending_load;
    logic [REGISTER_INDEX_WIDTH-1:0] pending_rd;

    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            is_byte;
    logic            aligned_mem;
    logic            misaligned_mem;
    logic [WORD_WIDTH-1:0] load_value;

    always_comb begin
        is_load        = cu_mem_to_reg_in;
        is_store       = !cu_mem_to_reg_in && (instruction_in[6:0] == STORE_OPCODE);
        is_mem         = is_load || is_store;
        // Any funct3 other than the byte code is treated as a word access.
        is_byte        = (instruction_in[14:12] == FUNCT3_BYTE);
        aligned_mem    = active_in && is_mem && (is_byte || alu_result_in[1:0] == 2'b00);
        misaligned_mem = active_in && is_mem && !is_byte && alu_result_in[1:0] != 2'b00;
    end

    assign stall_out   = (state != IDLE) || aligned_mem;
    assign debug_state = state;

    load_extender #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_load_extender (
        .read_data   (mem_read_data_in),
        .byte_access (mem_byte_out),
        .load_value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            pending_load       <= 1'b0;
            pending_rd         <= '0;
            mem_req_out        <= 1'b0;
            mem_write_out      <= 1'b0;
            mem_byte_out       <= 1'b0;
            mem_address_out    <= '0;
            mem_write_data_out <= '0;
            wb_value_out       <= '0;
            wb_destination_out <= '0;
            wb_reg_write_out   <= 1'b0;
            wb_active_out      <= 1'b0;
            misaligned_out     <= 1'b0;
        end else begin
            mem_req_out    <= 1'b0;
            misaligned_out <= 1'b0;
            case (state)
                IDLE: begin
                    wb_active_out <= 1'b0;
                    if (aligned_mem) begin
                        state              <= WAIT;
                        mem_req_out        <= 1'b1;
                        mem_write_out      <= is_store;
                        mem_byte_out       <= is_byte;
                        mem_address_out    <= alu_result_in;
                        mem_write_data_out <= store_data_in;
                        pending_load       <= is_load;
                        pending_rd         <= destination_register_in;
                    end else if (misaligned_mem) begin
                        misaligned_out <= 1'b1;
                    end else if (active_in) begin
                        wb_value_out       <= alu_result_in;
                        wb_destination_out <= destination_register_in;
                        wb_reg_write_out   <= cu_reg_write_in;
                        wb_active_out      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ready_in && !mem_req_out) begin
                        state              <= DONE;
                        if (pending_load) begin
                            wb_value_out <= load_value;
                        end
                        wb_destination_out <= pending_rd;
                        wb_reg_write_out   <= pending_load;
                        wb_active_out      <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    wb_active_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{extended_inmediate_in, alu_zero_in,
                             instruction_in[WORD_WIDTH-1:15], instruction_in[11:7]};

endmodule
